score_display_ctrl: RTL

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Converts an unsigned binary score into packed BCD digits for a
//   downstream 7-segment decoder, using one double-dabble iteration per cycle.
//   Scores above 10^NUM_HEX-1 are clamped, and sat reports the clamp.
//
// Handshake: a score transfers on a rising edge where score_valid and
//   score_ready are both 1. score_ready is high only in IDLE with clr low.
//   A score offered while score_ready is 0 is ignored, not queued.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (highest priority)
//   clr          synchronous display clear / conversion abort
//   score_valid  binary score offered
//   score        unsigned binary score, BIN_W bits
//   score_ready  block accepts a score this cycle
//   num          registered packed BCD, digit 0 in [3:0]
//   busy         conversion in progress (CONVERT or DONE)
//   done         single-cycle pulse, num just updated
//   sat          last accepted score was clamped
module score_display_ctrl #(
  parameter int NUM_HEX = 6,
  parameter int BIN_W   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   score_valid,
  input  logic [BIN_W-1:0]       score,
  output logic                   score_ready,
  output logic [NUM_HEX*4-1:0]   num,
  output logic                   busy,
  output logic                   done,
  output logic                   sat
);

  localparam int BW = NUM_HEX * 4;
  localparam int CW = $clog2(BIN_W + 1);

  // Largest value the display can show: 10^NUM_HEX - 1.
  function automatic logic [31:0] calc_max(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0]   MAXV     = calc_max(NUM_HEX);
  localparam logic [CW-1:0] CNT_INIT = CW'(BIN_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BIN_W-1:0] bin;
  logic [BW-1:0]    bcd;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_next;
  logic [BIN_W-1:0] bin_next;
  logic [31:0]      score_ext;
  logic             over;
  logic [BIN_W-1:0] clamped;

  assign score_ready = (state == S_IDLE) && !clr;
  assign busy        = (state != S_IDLE);

  // Clamp: the result always fits in BIN_W bits because it never exceeds score.
  assign score_ext = 32'(score);
  assign over      = (score_ext > MAXV);
  assign clamped   = over ? MAXV[BIN_W-1:0] : score;

  // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin}
  // left by one. The top BCD bit falls off; after clamping it is always zero.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < NUM_HEX; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    bcd_next = {adj[BW-2:0], bin[BIN_W-1]};
    bin_next = bin << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      num   <= '0;
      sat   <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
    end else if (clr) begin
      // Abort: drop any conversion in flight without a done pulse.
      state <= S_IDLE;
      num   <= '0;
      sat   <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // clr is low here, so score_ready is 1 and valid alone means transfer.
          if (score_valid) begin
            bin   <= clamped;
            sat   <= over;
            bcd   <= '0;
            cnt   <= CNT_INIT;
            state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bin <= bin_next;
          bcd <= bcd_next;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            num   <= bcd_next;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
